// File: rtl/alu_issue_stage.sv
// Two-register issue/result wrapper around an external combinational ALU.
// S0 holds the decoded op driving the ALU; S1 captures the ALU output with status flags.
module alu_issue_stage #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [DW-1:0] in_src1,
    input  logic [DW-1:0] in_src2,
    output logic [14:0]   alu_control,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    input  logic [DW-1:0] alu_result_i,
    input  logic [DW-1:0] div_odd_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [DW-1:0] out_rem,
    output logic          out_divz,
    output logic          out_illegal
);

    localparam logic [OPW-1:0] OP_DIV     = OPW'(3);
    localparam logic [OPW-1:0] OP_ILL_MIN = OPW'(14);

    logic           vld_p0;
    logic           vld_p1;
    logic [OPW-1:0] op_p0;
    logic           adv_p1;
    logic           accept;
    logic           divz_p0;
    logic           illegal_p0;

    // Opcodes 14 and above have no ALU function and decode to an all-zero control word.
    function automatic logic [14:0] decode_op(input logic [OPW-1:0] op);
        decode_op = '0;
        if (op < OP_ILL_MIN)
            decode_op = 15'(1) << op;
    endfunction

    assign adv_p1     = vld_p0 & (~vld_p1 | out_ready);
    assign in_ready   = ~vld_p0 | adv_p1;
    assign accept     = in_valid & in_ready;
    assign divz_p0    = (op_p0 == OP_DIV) && (alu_src2 == '0);
    assign illegal_p0 = (op_p0 >= OP_ILL_MIN);
    assign out_valid  = vld_p1;

    // ---- stage p0: issue registers feeding the ALU ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            op_p0       <= '0;
            alu_control <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
        end else if (accept) begin
            vld_p0      <= 1'b1;
            op_p0       <= in_op;
            alu_control <= decode_op(in_op);
            alu_src1    <= in_src1;
            alu_src2    <= in_src2;
        end else if (adv_p1) begin
            vld_p0      <= 1'b0;
            alu_control <= '0;
        end
    end

    // ---- stage p1: result registers offered downstream ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_result  <= '0;
            out_rem     <= '0;
            out_divz    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (adv_p1) begin
            vld_p1      <= 1'b1;
            out_divz    <= divz_p0;
            out_illegal <= illegal_p0;
            if (illegal_p0) begin
                out_result <= '0;
                out_rem    <= '0;
            end else if (divz_p0) begin
                out_result <= '1;
                out_rem    <= alu_src1;
            end else begin
                out_result <= alu_result_i;
                out_rem    <= div_odd_i;
            end
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, directed cases, then a randomized run
// with a queue-based reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic [14:0] alu_control;
    logic [31:0] alu_src1, alu_src2;
    logic [31:0] alu_result_i, div_odd_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_rem;
    logic        out_divz, out_illegal;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic [31:0] result;
        logic [31:0] rem;
        logic        divz;
        logic        illegal;
    } exp_t;

    op_t  pend[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   del_cnt = 0;
    bit   offer = 1'b1;

    alu_issue_stage #(.DW(32), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result_i(alu_result_i), .div_odd_i(div_odd_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rem(out_rem),
        .out_divz(out_divz), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode (src1 is the shift amount for shifts).
    function automatic logic [31:0] alu_fn(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a * b;
            3:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5:  return (a < b) ? 32'd1 : 32'd0;
            6:  return a & b;
            7:  return ~(a | b);
            8:  return a | b;
            9:  return a ^ b;
            10: return b << a[4:0];
            11: return b >> a[4:0];
            12: return $unsigned($signed(b) >>> a[4:0]);
            13: return {b[15:0], 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    // External ALU stand-in: reacts only to whichever control bit is set.
    always_comb begin
        alu_result_i = 32'h0;
        div_odd_i    = 32'h0;
        for (int k = 0; k < 14; k++) begin
            if (alu_control[k]) begin
                alu_result_i = alu_fn(k, alu_src1, alu_src2);
                if (k == 3 && alu_src2 != 0)
                    div_odd_i = alu_src1 % alu_src2;
            end
        end
    end

    function automatic exp_t model(input op_t o);
        exp_t e;
        e.result = 32'h0; e.rem = 32'h0; e.divz = 1'b0; e.illegal = 1'b0;
        if (o.op >= 14) begin
            e.illegal = 1'b1;
        end else if (o.op == 3 && o.b == 0) begin
            e.result = 32'hFFFF_FFFF; e.rem = o.a; e.divz = 1'b1;
        end else begin
            e.result = alu_fn(int'(o.op), o.a, o.b);
            if (o.op == 3) e.rem = o.a % o.b;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.op = op; o.a = a; o.b = b;
        pend.push_back(o);
    endtask

    // Called at a falling edge: drive, observe handshakes mid-cycle, advance one clock.
    task automatic cycle();
        exp_t e;
        in_valid = (pend.size() > 0) && offer;
        if (pend.size() > 0) begin
            in_op = pend[0].op; in_src1 = pend[0].a; in_src2 = pend[0].b;
        end
        #1;
        if (out_valid && out_ready) begin
            del_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_result", out_result, e.result);
                check("out_rem", out_rem, e.rem);
                check("out_divz", 32'(out_divz), 32'(e.divz));
                check("out_illegal", 32'(out_illegal), 32'(e.illegal));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(pend.pop_front()));
            acc_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int limit);
        for (int c = 0; c < limit && (pend.size() > 0 || exp_q.size() > 0); c++)
            cycle();
        check("drain_outstanding", 32'(pend.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        int a0, d0;
        logic [31:0] held;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_alu_src1", alu_src1, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_flags", {30'd0, out_divz, out_illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD latency: accept edge, then result valid after the next edge
        push(4'd0, 32'd5, 32'd7);
        cycle();
        check("add_alu_control", 32'(alu_control), 32'h0001);
        check("add_valid_early", 32'(out_valid), 32'd0);
        cycle();
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_result", out_result, 32'd12);
        drain(10);

        // SUB then SLTU back-to-back without a bubble
        push(4'd1, 32'd3, 32'd7);
        push(4'd5, 32'd3, 32'd7);
        a0 = acc_cnt; d0 = del_cnt;
        cycle(); cycle();
        check("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
        cycle(); cycle();
        check("b2b_delivered", 32'(del_cnt - d0), 32'd2);
        drain(10);

        // DIV normal and divide-by-zero
        push(4'd3, 32'd100, 32'd7);
        push(4'd3, 32'd9, 32'd0);
        drain(10);

        // Backpressure: only two ops fit while downstream stalls
        out_ready = 1'b0;
        push(4'd0, 32'd1, 32'd1);
        push(4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        push(4'd8, 32'h1200_0000, 32'h0000_0034);
        a0 = acc_cnt; d0 = del_cnt;
        repeat (3) cycle();
        check("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_result", out_result, 32'd2);
        held = out_result;
        repeat (3) cycle();
        check("bp_result_held", out_result, held);
        check("bp_alu_src2_held", alu_src2, 32'h0FF0_0FF0);
        out_ready = 1'b1;
        drain(20);
        check("bp_delivered", 32'(del_cnt - d0), 32'd3);

        // Illegal opcode
        push(4'd14, 32'd1, 32'd1);
        cycle();
        check("ill_alu_control", 32'(alu_control), 32'd0);
        cycle();
        check("ill_out_illegal", 32'(out_illegal), 32'd1);
        check("ill_out_result", out_result, 32'd0);
        drain(10);

        // Reset with both stages full drops everything
        out_ready = 1'b0;
        push(4'd2, 32'd6, 32'd7);
        push(4'd6, 32'hFF, 32'h0F);
        repeat (3) cycle();
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_alu_control", 32'(alu_control), 32'd0);
        check("mid_rst_out_result", out_result, 32'd0);
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        d0 = del_cnt;
        repeat (5) cycle();
        check("post_rst_no_output", 32'(del_cnt - d0), 32'd0);

        // Randomized traffic with random gaps and backpressure
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            rb = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
            if ($urandom_range(7) == 0) rb = 32'd0;
            push(4'($urandom_range(15)), ra, rb);
        end
        for (int c = 0; c < 5000 && (pend.size() > 0 || exp_q.size() > 0); c++) begin
            offer = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            cycle();
        end
        offer = 1'b1;
        out_ready = 1'b1;
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
